regwrite_trace_fifo: RTL and testbench
======================================

REGWRITE_TRACE_FIFO -- requirements
Module: regwrite_trace_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 16, FIFO entry count; power of two, 4..64.
REQ-002 SHALL have parameter CYCLE_W, default 16, width of the cycle stamp.
REQ-003 SHALL have port clock  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  one clock; reset is asynchronous and active-low (reset=0 clears state immediately).
REQ-005 SHALL have port ctrl_writeEnable  input  1  regfile write strobe from the processor.
REQ-006 SHALL have port ctrl_writeReg  input  5  destination register of the write.
REQ-007 SHALL have port data_writeReg  input  32  value being written.
REQ-008 SHALL have port clear  input  1  synchronous flush of FIFO and status.
REQ-009 SHALL have port out_valid  output  1  head entry available.
REQ-010 SHALL have port out_ready  input  1  consumer accepts head entry.
REQ-011 SHALL have port out_cycle  output  CYCLE_W  cycle stamp of head entry.
REQ-012 SHALL have port out_reg  output  5  register number of head entry.
REQ-013 SHALL have port out_data  output  32  written value of head entry.
REQ-014 SHALL have port count  output  $clog2(DEPTH)+1  current occupancy.
REQ-015 SHALL have port overflow  output  1  sticky: at least one write was dropped.
REQ-016 SHALL have port drop_count  output  8  dropped-write count (see Configuration).

Function
REQ-017 SHALL keep a free-running CYCLE_W-bit cycle counter, incremented every clock, wrapping from all-ones to 0; it is 0 in the first cycle after reset release.
REQ-018 SHALL push {cycle, ctrl_writeReg, data_writeReg} when ctrl_writeEnable=1 and ctrl_writeReg!=0; writes to r0 are never logged.
REQ-019 SHALL pop the head entry on a rising edge where out_valid=1 and out_ready=1.
REQ-020 SHALL assert out_valid from the cycle after the push into an empty FIFO (one-cycle latency); out_* are registered and hold stable while out_valid=1 and out_ready=0.
REQ-021 SHALL drive out_cycle/out_reg/out_data to 0 whenever out_valid=0.
REQ-022 SHALL, when full with no pop, drop the incoming write, set overflow, and leave contents unchanged.
REQ-023 SHALL, when full with a simultaneous pop, accept the push (count stays DEPTH, no overflow).
REQ-024 SHALL, when empty, ignore out_ready; a simultaneous push and pop on a non-empty, non-full FIFO leaves count unchanged.
REQ-025 SHALL implement read/write pointers with wrap-around modulo DEPTH; count = pushes minus pops, never exceeding DEPTH.
REQ-026 SHALL, on clear=1, empty the FIFO, clear overflow and drop_count, and discard any same-cycle push and pop; the cycle counter is not affected.
REQ-027 SHALL preserve entry order exactly (FIFO).

Reset
REQ-028 SHALL, while reset=0, force count=0, out_valid=0, out_cycle=0, out_reg=0, out_data=0, overflow=0, drop_count=0, cycle counter=0, pointers=0.
REQ-029 SHALL abandon any in-flight push/pop when reset asserts mid-operation; no entry survives reset.
REQ-030 SHALL resume normal operation on the first rising clock edge after reset returns to 1.

Configuration
REQ-031 SHALL honour macro TRACE_DROP_COUNT_EN: when defined, drop_count increments (saturating at 255) on every dropped write per REQ-022.
REQ-032 SHALL, when TRACE_DROP_COUNT_EN is undefined, tie drop_count to 0 and instantiate no counter; all other behaviour identical.

Verification
REQ-033 SHALL cover: reset release, write r5=0x0000002A at cycle 3, out_ready=1 -> out_valid at cycle 4 with out_cycle=3, out_reg=5, out_data=42, count returns to 0.
REQ-034 SHALL cover: write to r0 with value 7 -> count stays 0, out_valid stays 0.
REQ-035 SHALL cover: DEPTH=16, out_ready=0, 18 consecutive writes r1..r18 -> count=16, overflow=1, drop_count=2 (macro on) / 0 (macro off); drain yields r1..r16 in order.
REQ-036 SHALL cover: full FIFO, push and pop same edge -> count=16, overflow=0, new entry appears last.
REQ-037 SHALL cover: 3 entries queued, reset driven low between edges -> outputs 0 immediately, count=0 after release; clear=1 with 5 entries -> count=0, overflow=0 next cycle.
REQ-038 SHALL cover: cycle counter wrap with CYCLE_W=4 -> write at 16th cycle after release stamped 0.

Source files
------------

// File: rtl/regwrite_trace_fifo_if.sv
// regwrite_trace_fifo_if: trace output stream; master is the FIFO, slave is the consumer.
interface regwrite_trace_fifo_if #(parameter int CYCLE_W = 16);
    logic               out_valid;
    logic               out_ready;
    logic [CYCLE_W-1:0] out_cycle;
    logic [4:0]         out_reg;
    logic [31:0]        out_data;
    modport master (output out_valid, out_cycle, out_reg, out_data, input out_ready);
    modport slave  (input out_valid, out_cycle, out_reg, out_data, output out_ready);
endinterface

// File: rtl/regwrite_trace_fifo.sv
// regwrite_trace_fifo: cycle-stamped FIFO of register-file writes; r0 writes are never logged.
// Optional TRACE_DROP_COUNT_EN adds a saturating 8-bit count of dropped writes.
module regwrite_trace_fifo #(
    parameter int DEPTH   = 16,
    parameter int CYCLE_W = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     ctrl_writeEnable,
    input  logic [4:0]               ctrl_writeReg,
    input  logic [31:0]              data_writeReg,
    input  logic                     clear,
    regwrite_trace_fifo_if.master    tr,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic [7:0]               drop_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int EW = CYCLE_W + 37;

    logic [EW-1:0]      mem_q [DEPTH];
    logic [AW-1:0]      wr_q, wr_d, rd_q, rd_d;
    logic [AW:0]        cnt_q, cnt_d;
    logic [CYCLE_W-1:0] cyc_q, cyc_d;
    logic               ovf_q, ovf_d;
    logic               valid, push_req, pop, push, drop;

    always_comb begin
        valid    = cnt_q != '0;
        pop      = valid && tr.out_ready;
        push_req = ctrl_writeEnable && ctrl_writeReg != 5'd0;
        // A full FIFO still accepts a write when the head leaves on the same edge.
        push     = push_req && (cnt_q != (AW+1)'(DEPTH) || pop);
        drop     = push_req && !push;
        cyc_d    = cyc_q + 1'b1;
        wr_d     = clear ? '0 : wr_q + AW'(push);
        rd_d     = clear ? '0 : rd_q + AW'(pop);
        cnt_d    = clear ? '0 : cnt_q + (AW+1)'(push) - (AW+1)'(pop);
        ovf_d    = !clear && (ovf_q || drop);
    end

    always_ff @(posedge clock or negedge reset)
        if (!reset) begin
            cyc_q <= '0;
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            cyc_q <= cyc_d;
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end

    // Storage needs no reset: nothing is visible unless count says it is valid.
    always_ff @(posedge clock)
        if (push && !clear) mem_q[wr_q] <= {cyc_q, ctrl_writeReg, data_writeReg};

    assign tr.out_valid = valid;
    assign {tr.out_cycle, tr.out_reg, tr.out_data} = valid ? mem_q[rd_q] : '0;
    assign count    = cnt_q;
    assign overflow = ovf_q;

`ifdef TRACE_DROP_COUNT_EN
    logic [7:0] dc_q, dc_d;
    always_comb dc_d = clear ? 8'd0 : dc_q + 8'(drop && dc_q != 8'hff);
    always_ff @(posedge clock or negedge reset)
        if (!reset) dc_q <= 8'd0;
        else        dc_q <= dc_d;
    assign drop_count = dc_q;
`else
    assign drop_count = 8'd0;
`endif
endmodule

// File: tb/tb_regwrite_trace_fifo.sv
// tb_regwrite_trace_fifo: scoreboard bench for regwrite_trace_fifo (default build and CYCLE_W=4 wrap instance).
module tb_regwrite_trace_fifo;
    typedef logic [52:0] entry_t;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        we = 1'b0, clr = 1'b0;
    logic [4:0]  wreg = '0;
    logic [31:0] wdata = '0;
    logic [4:0]  count0, count1;
    logic        ovf0, ovf1;
    logic [7:0]  drop0, drop1;

    int     checks = 0, errors = 0;
    int     tb_cyc;
    int     exp_drop = 0;
    logic   exp_ovf = 1'b0;
    entry_t q[$];

    regwrite_trace_fifo_if #(.CYCLE_W(16)) t0 ();
    regwrite_trace_fifo_if #(.CYCLE_W(4))  t1 ();

    regwrite_trace_fifo u0 (.clock(clock), .reset(reset), .ctrl_writeEnable(we), .ctrl_writeReg(wreg),
        .data_writeReg(wdata), .clear(clr), .tr(t0), .count(count0), .overflow(ovf0), .drop_count(drop0));
    regwrite_trace_fifo #(.DEPTH(16), .CYCLE_W(4)) u1 (.clock(clock), .reset(reset), .ctrl_writeEnable(we),
        .ctrl_writeReg(wreg), .data_writeReg(wdata), .clear(clr), .tr(t1), .count(count1), .overflow(ovf1),
        .drop_count(drop1));

    always #5 clock = ~clock;
    initial t1.out_ready = 1'b1;

    always @(posedge clock or negedge reset)
        if (!reset) tb_cyc <= 0;
        else        tb_cyc <= tb_cyc + 1;

    function automatic logic [7:0] exp_dc();
`ifdef TRACE_DROP_COUNT_EN
        return 8'(exp_drop);
`else
        return 8'd0;
`endif
    endfunction

    // One clock cycle: check outputs against the model, drive inputs, update the model, advance.
    task automatic step(input logic w, input logic [4:0] r, input logic [31:0] d, input logic rdy, input logic c);
        logic pop_m, push_m, drop_m;
        checks++;
        if (count0 !== 5'(q.size())) begin errors++; $display("FAIL count: got %0d expected %0d", count0, q.size()); end
        checks++;
        if (t0.out_valid !== (q.size() != 0)) begin errors++; $display("FAIL out_valid: got %0b expected %0b", t0.out_valid, q.size() != 0); end
        checks++;
        if (ovf0 !== exp_ovf) begin errors++; $display("FAIL overflow: got %0b expected %0b", ovf0, exp_ovf); end
        checks++;
        if (drop0 !== exp_dc()) begin errors++; $display("FAIL drop_count: got %0d expected %0d", drop0, exp_dc()); end
        checks++;
        if (q.size() != 0) begin
            if ({t0.out_cycle, t0.out_reg, t0.out_data} !== q[0]) begin
                errors++;
                $display("FAIL head: got cyc=%0d reg=%0d data=%0h expected cyc=%0d reg=%0d data=%0h",
                         t0.out_cycle, t0.out_reg, t0.out_data, q[0][52:37], q[0][36:32], q[0][31:0]);
            end
        end else if ({t0.out_cycle, t0.out_reg, t0.out_data} !== 53'd0) begin
            errors++;
            $display("FAIL idle_out: got cyc=%0d reg=%0d data=%0h expected 0", t0.out_cycle, t0.out_reg, t0.out_data);
        end
        pop_m  = q.size() != 0 && rdy && !c;
        push_m = w && r != 0 && !c && (q.size() < 16 || pop_m);
        drop_m = w && r != 0 && !c && !push_m;
        if (c) begin
            q.delete();
            exp_ovf  = 1'b0;
            exp_drop = 0;
        end else begin
            if (pop_m) void'(q.pop_front());
            if (push_m) q.push_back({16'(tb_cyc), r, d});
            if (drop_m) begin
                exp_ovf = 1'b1;
                if (exp_drop < 255) exp_drop++;
            end
        end
        we = w; wreg = r; wdata = d; t0.out_ready = rdy; clr = c;
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int i = 0; i < n; i++) step(1'b0, 5'd0, 32'd0, rdy, 1'b0);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        we = 1'b0; wreg = '0; wdata = '0; clr = 1'b0; t0.out_ready = 1'b0;
        q.delete();
        exp_ovf = 1'b0;
        exp_drop = 0;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        @(negedge clock);
        checks++;
        if ({t0.out_valid, count0, ovf0, drop0} !== 15'd0) begin
            errors++;
            $display("FAIL reset_status: got valid=%0b count=%0d ovf=%0b drop=%0d expected 0", t0.out_valid, count0, ovf0, drop0);
        end
        checks++;
        if ({t0.out_cycle, t0.out_reg, t0.out_data} !== 53'd0) begin
            errors++;
            $display("FAIL reset_out: got %0h expected 0", {t0.out_cycle, t0.out_reg, t0.out_data});
        end
        do_reset();
        idle(2, 1'b0);
    endtask

    task automatic test_basic();
        do_reset();
        idle(3, 1'b1);
        step(1'b1, 5'd5, 32'h0000002A, 1'b1, 1'b0);
        checks++;
        if (t0.out_cycle !== 16'd3) begin errors++; $display("FAIL basic_stamp: got %0d expected 3", t0.out_cycle); end
        idle(2, 1'b1);
    endtask

    task automatic test_r0();
        step(1'b1, 5'd0, 32'd7, 1'b1, 1'b0);
        step(1'b1, 5'd0, 32'd7, 1'b0, 1'b0);
        idle(1, 1'b1);
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 1; i <= 18; i++) step(1'b1, 5'(i), 32'(i * 32'h1111), 1'b0, 1'b0);
        idle(1, 1'b0);
        checks++;
        if (count0 !== 5'd16 || ovf0 !== 1'b1) begin
            errors++;
            $display("FAIL overflow_full: got count=%0d ovf=%0b expected 16 1", count0, ovf0);
        end
        idle(17, 1'b1);
    endtask

    task automatic test_full_pushpop();
        do_reset();
        for (int i = 1; i <= 16; i++) step(1'b1, 5'(i), 32'(i), 1'b0, 1'b0);
        step(1'b1, 5'd20, 32'hABC, 1'b1, 1'b0);
        checks++;
        if (count0 !== 5'd16 || ovf0 !== 1'b0) begin
            errors++;
            $display("FAIL full_pushpop: got count=%0d ovf=%0b expected 16 0", count0, ovf0);
        end
        idle(17, 1'b1);
    endtask

    task automatic test_reset_midop_and_clear();
        for (int i = 1; i <= 3; i++) step(1'b1, 5'(i + 3), 32'(i), 1'b0, 1'b0);
        #2 reset = 1'b0;
        #1;
        checks++;
        if ({t0.out_valid, count0, t0.out_cycle, t0.out_reg, t0.out_data} !== 59'd0) begin
            errors++;
            $display("FAIL midop_reset: got valid=%0b count=%0d out=%0h expected 0", t0.out_valid, count0,
                     {t0.out_cycle, t0.out_reg, t0.out_data});
        end
        do_reset();
        idle(2, 1'b1);
        for (int i = 1; i <= 17; i++) step(1'b1, 5'(i), 32'(i + 100), 1'b0, 1'b0);
        idle(11, 1'b1);
        step(1'b1, 5'd9, 32'h55, 1'b1, 1'b1);
        checks++;
        if (count0 !== 5'd0 || ovf0 !== 1'b0) begin
            errors++;
            $display("FAIL clear: got count=%0d ovf=%0b expected 0 0", count0, ovf0);
        end
        idle(2, 1'b1);
    endtask

    task automatic test_wrap();
        logic [3:0] stamp;
        do_reset();
        idle(16, 1'b1);
        stamp = 4'(tb_cyc);
        step(1'b1, 5'd9, 32'h99, 1'b1, 1'b0);
        checks++;
        if (t1.out_valid !== 1'b1 || t1.out_cycle !== stamp || t1.out_reg !== 5'd9) begin
            errors++;
            $display("FAIL wrap_stamp: got valid=%0b cyc=%0d reg=%0d expected 1 %0d 9", t1.out_valid, t1.out_cycle, t1.out_reg, stamp);
        end
        idle(2, 1'b1);
    endtask

    initial begin
        @(negedge clock);
        test_reset();
        test_basic();
        test_r0();
        test_overflow();
        test_full_pushpop();
        test_reset_midop_and_clear();
        test_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
